// File: rtl/xdebounce_in_if.sv
// Register bus between the address decoder and the debounced input block.
// The decoder drives select/write/address/data; the block returns combinational read data.
interface xdebounce_in_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output sel, we, addr, data_in, input data_out);
    modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xdebounce_in.sv
// N-channel debounced input peripheral: per-channel synchroniser, debounce counter,
// sticky W1C rise/fall flags, and a 4-register read/write map on the data bus.
module xdebounce_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
    input  logic [CNT_W-1:0] period,
    input  logic             clr_rise,
    input  logic             clr_fall,
    output logic             stable,
    output logic             rise,
    output logic             fall
);
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Compared against the live period, so a lowered period can accept immediately.
    assign accept = (sync2 != stable) && (cnt >= period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A new edge beats a same-cycle clear.
            rise <= (accept &  sync2) | (rise & ~clr_rise);
            fall <= (accept & ~sync2) | (fall & ~clr_fall);
        end
    end
endmodule

module xdebounce_in #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int DB_DEFAULT = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pin_in,
    xdebounce_in_if.slave   bus,
    output logic            irq
);
    localparam logic [1:0] A_STATE = 2'd0;
    localparam logic [1:0] A_RISE  = 2'd1;
    localparam logic [1:0] A_FALL  = 2'd2;
    localparam logic [1:0] A_CFG   = 2'd3;

    logic [CNT_W-1:0]  cfg;
    logic [N_CH-1:0]   stable, rise, fall;
    logic [N_CH-1:0]   clr_rise, clr_fall;
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic              unused_data;

    assign wr          = bus.sel & bus.we;
    assign clr_rise    = (wr && bus.addr == A_RISE) ? bus.data_in[N_CH-1:0] : '0;
    assign clr_fall    = (wr && bus.addr == A_FALL) ? bus.data_in[N_CH-1:0] : '0;
    assign unused_data = ^bus.data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cfg <= CNT_W'(DB_DEFAULT);
        else if (wr && bus.addr == A_CFG)
            cfg <= bus.data_in[CNT_W-1:0];
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        xdebounce_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .pin      (pin_in[g]),
            .period   (cfg),
            .clr_rise (clr_rise[g]),
            .clr_fall (clr_fall[g]),
            .stable   (stable[g]),
            .rise     (rise[g]),
            .fall     (fall[g])
        );
    end

    assign irq = |{rise, fall};

    always_comb begin
        rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                A_STATE: rdata[N_CH-1:0]  = stable;
                A_RISE:  rdata[N_CH-1:0]  = rise;
                A_FALL:  rdata[N_CH-1:0]  = fall;
                default: rdata[CNT_W-1:0] = cfg;
            endcase
        end
    end

    assign bus.data_out = rdata;
endmodule

// File: tb/tb_xdebounce_in.sv
// Scoreboarded bench for xdebounce_in: reads push expected values, a negedge monitor compares.
module tb_xdebounce_in;
    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int DB     = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] pin_in = '0;
    logic            irq;

    xdebounce_in_if #(.DATA_W(DATA_W)) bus ();

    xdebounce_in #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DB_DEFAULT(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pin_in (pin_in),
        .bus    (bus.slave),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: any read cycle consumes one expected entry.
    always @(negedge clk) begin
        if (bus.sel && !bus.we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%0d data=%h", bus.addr, bus.data_out);
            end else begin
                e = sb.pop_front();
                if (bus.data_out !== e.data || irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s got data=%h irq=%b expected data=%h irq=%b",
                             e.name, bus.data_out, irq, e.data, e.irq);
                end
            end
        end else if (!bus.sel) begin
            checks++;
            if (bus.data_out !== '0) begin
                errors++;
                $display("FAIL idle_data got %h expected 0", bus.data_out);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic i, input string n);
        exp_t x;
        x.name = n; x.data = d; x.irq = i;
        sb.push_back(x);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
        @(posedge clk);
        #1;
        // 1. reset state
        rd(0, 32'h0, 1'b0, "rst_state");
        rst = 1'b0;
        rd(3, DB,    1'b0, "cfg_default");
        rd(0, 32'h0, 1'b0, "state_0");
        rd(1, 32'h0, 1'b0, "rise_0");
        rd(2, 32'h0, 1'b0, "fall_0");

        // 2. P=3, channel 0 accepted exactly at edge 6
        wr(3, 3);
        pin_in = 4'b0001;
        tick(5);
        rd(0, 32'h0, 1'b0, "state_edge5");
        rd(0, 32'h1, 1'b1, "state_edge6");
        rd(1, 32'h1, 1'b1, "rise_ch0");
        rd(2, 32'h0, 1'b1, "fall_ch0_none");

        // 3. 3-cycle glitch rejected, 4-cycle pulse accepted then falls
        pin_in = 4'b0011;
        tick(3);
        pin_in = 4'b0001;
        tick(10);
        rd(0, 32'h1, 1'b1, "glitch_state");
        rd(1, 32'h1, 1'b1, "glitch_rise");
        rd(2, 32'h0, 1'b1, "glitch_fall");
        pin_in = 4'b0011;
        tick(4);
        pin_in = 4'b0001;
        tick(2);
        rd(0, 32'h3, 1'b1, "pulse4_state");
        tick(2);
        rd(2, 32'h0, 1'b1, "pulse4_fall_early");
        rd(2, 32'h2, 1'b1, "pulse4_fall");
        rd(0, 32'h1, 1'b1, "pulse4_state_after");
        rd(1, 32'h3, 1'b1, "pulse4_rise");

        // 4. W1C behaviour with RISE=0x5
        pin_in = 4'b0100;
        tick(10);
        pin_in = 4'b0101;
        tick(10);
        wr(1, 32'h2);
        wr(2, 32'hF);
        rd(1, 32'h5, 1'b1, "rise_5");
        wr(1, 32'h4);
        rd(1, 32'h1, 1'b1, "w1c_bit2");
        wr(1, 32'h1);
        rd(1, 32'h0, 1'b0, "w1c_bit0");
        wr(1, 32'h0);
        rd(1, 32'h0, 1'b0, "w1c_zero");
        wr(0, 32'hF);
        rd(0, 32'h5, 1'b0, "state_ro");

        // 5. set beats same-cycle clear on channel 2
        pin_in = 4'b0001;
        tick(10);
        wr(2, 32'h4);
        pin_in = 4'b0101;
        tick(5);
        wr(1, 32'h4);
        rd(1, 32'h4, 1'b1, "set_wins");
        rd(0, 32'h5, 1'b1, "set_wins_state");

        // 6a. P=0: accepted at edge 3
        wr(1, 32'hF);
        wr(3, 0);
        pin_in = 4'b1101;
        tick(2);
        rd(0, 32'h5, 1'b0, "p0_edge2");
        rd(0, 32'hD, 1'b1, "p0_edge3");
        rd(3, 32'h0, 1'b1, "cfg_0");

        // 6b. reset mid-count, then default period after release
        pin_in = 4'b0000;
        tick(5);
        wr(2, 32'hF);
        wr(1, 32'hF);
        rd(0, 32'h0, 1'b0, "all_low");
        wr(3, 100);
        pin_in = 4'b0001;
        tick(52);
        rst = 1'b1;
        rd(0, 32'h0, 1'b0, "midreset_state");
        rd(3, DB,    1'b0, "midreset_cfg");
        rst = 1'b0;
        tick(102);
        rd(0, 32'h0, 1'b0, "rel_edge102");
        rd(0, 32'h1, 1'b1, "rel_edge103");
        rd(1, 32'h1, 1'b1, "rel_rise");
        rd(2, 32'h0, 1'b1, "rel_fall");
        rd(3, DB,    1'b1, "rel_cfg");

        tick(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
